// File: rtl/sample_readout_fifo.sv
// Sample buffer between the capture stage and the Raspberry Pi: a small circular FIFO
// feeding a single registered presentation word that the RPi acknowledges with a rising edge on ready.
module sample_readout_fifo #(
    parameter int DATA_W     = 24,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  ready,
    output logic [DATA_W-1:0]     data,
    output logic                  rpi_interrupt,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FILL_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PRESENT
    } state_e;

    state_e                  state_q;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]     fill_q, fill_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_W-1:0]       data_q;
    logic                    intr_q;
    logic                    r1_q, r2_q, r3_q;

    logic full;
    logic push;
    logic drop;
    logic pop;
    logic ack;

    // fill never exceeds DEPTH, so its top bit alone marks the full condition
    assign full = fill_q[DEPTH_LOG2];
    assign push = in_valid & ~full;
    assign drop = in_valid & full;
    assign pop  = (state_q == LOAD);
    assign ack  = r2_q & ~r3_q;

    always_comb begin
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Synchroniser flops reset high so a ready line held high through reset never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_q <= 1'b1;
            r2_q <= 1'b1;
            r3_q <= 1'b1;
        end else begin
            r1_q <= ready;
            r2_q <= r1_q;
            r3_q <= r2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
        end
    end

    // Acks arriving outside PRESENT are dropped rather than remembered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            data_q   <= '0;
            intr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    intr_q <= 1'b0;
                    if (fill_q != '0) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    data_q   <= mem_q[rd_ptr_q];
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                    intr_q   <= 1'b1;
                    state_q  <= PRESENT;
                end
                PRESENT: begin
                    if (ack) begin
                        intr_q  <= 1'b0;
                        state_q <= (fill_q != '0) ? LOAD : IDLE;
                    end
                end
                default: begin
                    intr_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready      = ~full;
    assign data          = data_q;
    assign rpi_interrupt = intr_q;
    assign fill          = fill_q;
    assign overflow      = ovf_q;

endmodule
